bitmanip_exec_pipe: RTL and testbench

- Two-stage pipelined Zbb-subset execution unit. It sits between issue/dispatch and writeback/ROB in the backend.
- Accepts one op per cycle over a valid/ready handshake. Returns a 32-bit result tagged with the ROB tag and destination register.
- Supports back-pressure from writeback and a pipeline flush on branch mispredict or exception.

---
 rtl/bitutils_pkg.sv | 32 +++
 rtl/bm_count_unit.sv | 37 +++
 rtl/bitmanip_exec_pipe.sv | 135 +++++++++++++
 tb/tb_bitmanip_exec_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitutils_pkg.sv
// Shared types and helpers for the Zbb-subset bit-manipulation execution unit.
// Holds the word type, the op encoding and the byte-wise helper functions used in stage S2.
package bitutils;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        BM_CLZ  = 3'd0,
        BM_CTZ  = 3'd1,
        BM_CPOP = 3'd2,
        BM_REV8 = 3'd3,
        BM_ORCB = 3'd4,
        BM_ROL  = 3'd5,
        BM_ROR  = 3'd6,
        BM_ANDN = 3'd7
    } bm_op_t;

    localparam int BM_LATENCY = 2;

    function automatic word_t rev8(input word_t a);
        return {a[7:0], a[15:8], a[23:16], a[31:24]};
    endfunction

    function automatic word_t orcb(input word_t a);
        word_t r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = (|a[i*8 +: 8]) ? 8'hFF : 8'h00;
        end
        return r;
    endfunction

endpackage

// File: rtl/bm_count_unit.sv
// Combinational leading-zero, trailing-zero and population count of one 32-bit word.
// Each count is 0..32, so a 6-bit result is enough.
module bm_count_unit (
    input  logic [31:0] i_word,
    output logic [5:0]  o_clz,
    output logic [5:0]  o_ctz,
    output logic [5:0]  o_cpop
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        o_clz = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (i_word[i]) begin
                o_clz = 6'(31 - i);
            end
        end
    end

    // Descending scan: the last set bit seen is the least significant one.
    always_comb begin
        o_ctz = 6'd32;
        for (int i = 31; i >= 0; i--) begin
            if (i_word[i]) begin
                o_ctz = 6'(i);
            end
        end
    end

    always_comb begin
        o_cpop = 6'd0;
        for (int i = 0; i < 32; i++) begin
            o_cpop = o_cpop + {5'd0, i_word[i]};
        end
    end

endmodule

// File: rtl/bitmanip_exec_pipe.sv
// Two-stage Zbb-subset execution unit: S1 captures the issued op, S2 computes the result
// into the output registers. Valid/ready on both sides, flush drops everything in flight.
module bitmanip_exec_pipe
    import bitutils::*;
#(
    parameter int TAG_WIDTH = 6,
    parameter int RD_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [31:0]          in_rs1,
    input  logic [31:0]          in_rs2,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic [RD_WIDTH-1:0]  in_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [RD_WIDTH-1:0]  out_rd
);

    logic                 r_s1Valid;
    bm_op_t               r_s1Op;
    word_t                r_s1Rs1;
    word_t                r_s1Rs2;
    logic [TAG_WIDTH-1:0] r_s1Tag;
    logic [RD_WIDTH-1:0]  r_s1Rd;

    logic                 r_outValid;
    word_t                r_outResult;
    logic [TAG_WIDTH-1:0] r_outTag;
    logic [RD_WIDTH-1:0]  r_outRd;

    logic                 w_s2Adv;
    logic                 w_accept;
    logic [5:0]           w_clz;
    logic [5:0]           w_ctz;
    logic [5:0]           w_cpop;
    logic [4:0]           w_shamt;
    word_t                w_rol;
    word_t                w_ror;
    word_t                w_result;

    // Flush blocks intake for its own cycle so nothing new slips in behind the discard.
    assign w_s2Adv  = r_s1Valid & (~r_outValid | out_ready);
    assign in_ready = ~flush & (~r_s1Valid | w_s2Adv);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_outValid <= 1'b0;
        end else if (flush) begin
            r_s1Valid  <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1Valid <= 1'b1;
            end else if (w_s2Adv) begin
                r_s1Valid <= 1'b0;
            end
            if (w_s2Adv) begin
                r_outValid <= 1'b1;
            end else if (out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Op  <= BM_CLZ;
            r_s1Rs1 <= '0;
            r_s1Rs2 <= '0;
            r_s1Tag <= '0;
            r_s1Rd  <= '0;
        end else if (w_accept) begin
            r_s1Op  <= bm_op_t'(in_op);
            r_s1Rs1 <= in_rs1;
            r_s1Rs2 <= in_rs2;
            r_s1Tag <= in_tag;
            r_s1Rd  <= in_rd;
        end
    end

    bm_count_unit u_count (
        .i_word (r_s1Rs1),
        .o_clz  (w_clz),
        .o_ctz  (w_ctz),
        .o_cpop (w_cpop)
    );

    // A 6-bit complement shift of 32 yields zero, so amount 0 returns rs1 untouched.
    assign w_shamt = r_s1Rs2[4:0];
    assign w_rol   = (r_s1Rs1 << w_shamt) | (r_s1Rs1 >> (6'd32 - {1'b0, w_shamt}));
    assign w_ror   = (r_s1Rs1 >> w_shamt) | (r_s1Rs1 << (6'd32 - {1'b0, w_shamt}));

    always_comb begin
        w_result = '0;
        case (r_s1Op)
            BM_CLZ:  w_result = {26'd0, w_clz};
            BM_CTZ:  w_result = {26'd0, w_ctz};
            BM_CPOP: w_result = {26'd0, w_cpop};
            BM_REV8: w_result = rev8(r_s1Rs1);
            BM_ORCB: w_result = orcb(r_s1Rs1);
            BM_ROL:  w_result = w_rol;
            BM_ROR:  w_result = w_ror;
            BM_ANDN: w_result = r_s1Rs1 & ~r_s1Rs2;
            default: w_result = '0;
        endcase
    end

    // Output payload only moves when S2 advances, which keeps it stable during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outResult <= '0;
            r_outTag    <= '0;
            r_outRd     <= '0;
        end else if (w_s2Adv) begin
            r_outResult <= w_result;
            r_outTag    <= r_s1Tag;
            r_outRd     <= r_s1Rd;
        end
    end

    assign out_valid  = r_outValid;
    assign out_result = r_outResult;
    assign out_tag    = r_outTag;
    assign out_rd     = r_outRd;

endmodule

// File: tb/tb_bitmanip_exec_pipe.sv
// Self-checking bench for bitmanip_exec_pipe: directed vector table, back-pressure,
// flush and async-reset sequences, then randomized traffic against a queue-based model.
module tb_bitmanip_exec_pipe;
    import bitutils::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [5:0]  in_tag;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [5:0]  out_tag;
    logic [4:0]  out_rd;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic [5:0]  tag;
        logic [4:0]  rd;
    } exp_t;

    vec_t  vecs[15];
    exp_t  expQ[$];
    int    tests;
    int    failures;
    logic  stallValid;
    logic [31:0] stallRes;
    logic [5:0]  stallTag;
    logic [4:0]  stallRd;
    logic  dummy;

    bitmanip_exec_pipe #(.TAG_WIDTH(6), .RD_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_rd     (out_rd)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour, written straight from the instruction definitions.
    function automatic logic [31:0] modelOp(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        int n;
        int amt;
        r = '0;
        case (op)
            3'd0: begin
                n = 0;
                while (n < 32 && a[31-n] == 1'b0) n++;
                r = n;
            end
            3'd1: begin
                n = 0;
                while (n < 32 && a[n] == 1'b0) n++;
                r = n;
            end
            3'd2: r = $countones(a);
            3'd3: r = {a[7:0], a[15:8], a[23:16], a[31:24]};
            3'd4: begin
                for (int k = 0; k < 4; k++) begin
                    r[k*8 +: 8] = (a[k*8 +: 8] != 8'h00) ? 8'hFF : 8'h00;
                end
            end
            3'd5: begin
                amt = int'(b % 32);
                r = a;
                repeat (amt) r = {r[30:0], r[31]};
            end
            3'd6: begin
                amt = int'(b % 32);
                r = a;
                repeat (amt) r = {r[0], r[31:1]};
            end
            default: r = a & ~b;
        endcase
        return r;
    endfunction

    // One counted comparison; prints a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [5:0] tag,
                                 input logic [4:0] rd);
        in_valid = v;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        in_rd    = rd;
    endtask

    // Advance one clock from a negedge to the next negedge, scoring transfers and stalls.
    task automatic stepCycle(output logic accepted);
        logic acc;
        logic xfer;
        logic fl;
        exp_t it;
        exp_t nw;
        #1;
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        fl   = flush;
        if (stallValid) begin
            checkOutput("stallValid", {31'd0, out_valid}, 32'd1);
            checkOutput("stallResult", out_result, stallRes);
            checkOutput("stallTag", {26'd0, out_tag}, {26'd0, stallTag});
            checkOutput("stallRd", {27'd0, out_rd}, {27'd0, stallRd});
        end
        stallValid = out_valid && !out_ready && !fl;
        stallRes   = out_result;
        stallTag   = out_tag;
        stallRd    = out_rd;
        if (xfer) begin
            if (expQ.size() == 0) begin
                tests++;
                failures++;
                $display("[TB] FAIL unexpectedResult: got tag %h result %h, expected none",
                         out_tag, out_result);
            end else begin
                it = expQ.pop_front();
                checkOutput("sbResult", out_result, it.result);
                checkOutput("sbTag", {26'd0, out_tag}, {26'd0, it.tag});
                checkOutput("sbRd", {27'd0, out_rd}, {27'd0, it.rd});
            end
        end
        if (acc) begin
            nw.result = modelOp(in_op, in_rs1, in_rs2);
            nw.tag    = in_tag;
            nw.rd     = in_rd;
        end
        @(posedge clk);
        if (fl) expQ.delete();
        if (acc) expQ.push_back(nw);
        accepted = acc;
        @(negedge clk);
    endtask

    initial begin
        logic acc;
        int   idx;
        logic [2:0]  bpOp[4];
        logic [31:0] bpA[4];
        logic [31:0] bpB[4];

        tests      = 0;
        failures   = 0;
        stallValid = 1'b0;
        rst        = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 6'd0, 5'd0);

        vecs[0]  = '{3'd0, 32'h0000_0000, 32'h0, 32'd32};
        vecs[1]  = '{3'd0, 32'h0001_0000, 32'h0, 32'd15};
        vecs[2]  = '{3'd0, 32'h8000_0000, 32'h0, 32'd0};
        vecs[3]  = '{3'd1, 32'h0000_0100, 32'h0, 32'd8};
        vecs[4]  = '{3'd1, 32'h0000_0000, 32'h0, 32'd32};
        vecs[5]  = '{3'd2, 32'hFFFF_FFFF, 32'h0, 32'd32};
        vecs[6]  = '{3'd2, 32'h0F0F_0001, 32'h0, 32'd9};
        vecs[7]  = '{3'd3, 32'h1234_5678, 32'h0, 32'h7856_3412};
        vecs[8]  = '{3'd4, 32'h0010_0080, 32'h0, 32'h00FF_00FF};
        vecs[9]  = '{3'd7, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0000};
        vecs[10] = '{3'd5, 32'h8000_0001, 32'h0000_0021, 32'h0000_0003};
        vecs[11] = '{3'd6, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
        vecs[12] = '{3'd5, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF};
        vecs[13] = '{3'd6, 32'h1234_5678, 32'hFFFF_FFE4, 32'h8123_4567};
        vecs[14] = '{3'd1, 32'h8000_0000, 32'h0, 32'd31};

        // Reset values must be visible while reset is held, before any clock edge.
        #1;
        checkOutput("resetOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("resetOutResult", out_result, 32'd0);
        checkOutput("resetOutTag", {26'd0, out_tag}, 32'd0);
        checkOutput("resetOutRd", {27'd0, out_rd}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("resetInReady", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Directed table: one op at a time, result due exactly two edges after accept.
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].rs1, vecs[i].rs2, 6'(i + 3), 5'(i + 1));
            stepCycle(acc);
            checkOutput($sformatf("vec%0dAccept", i), {31'd0, acc}, 32'd1);
            in_valid = 1'b0;
            #1;
            checkOutput($sformatf("vec%0dEarly", i), {31'd0, out_valid}, 32'd0);
            stepCycle(dummy);
            #1;
            checkOutput($sformatf("vec%0dValid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("vec%0dResult", i), out_result, vecs[i].exp);
            checkOutput($sformatf("vec%0dTag", i), {26'd0, out_tag}, 32'(i + 3));
            stepCycle(dummy);
        end

        // Back-pressure: with writeback stalled only two ops fit, then order is preserved.
        bpOp[0] = 3'd2; bpA[0] = 32'h0000_00FF; bpB[0] = 32'h0;
        bpOp[1] = 3'd3; bpA[1] = 32'hAABB_CCDD; bpB[1] = 32'h0;
        bpOp[2] = 3'd5; bpA[2] = 32'h1234_5678; bpB[2] = 32'h8;
        bpOp[3] = 3'd7; bpA[3] = 32'hFFFF_FFFF; bpB[3] = 32'h0000_FFFF;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, bpOp[idx], bpA[idx], bpB[idx], 6'(10 + idx), 5'(idx));
            stepCycle(acc);
            if (acc) idx++;
        end
        #1;
        checkOutput("bpAcceptCount", 32'(idx), 32'd2);
        checkOutput("bpInReadyLow", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (idx < 4) applyStimulus(1'b1, bpOp[idx], bpA[idx], bpB[idx], 6'(10 + idx), 5'(idx));
            else in_valid = 1'b0;
            #1;
            checkOutput($sformatf("bpDrain%0dValid", c), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("bpDrain%0dTag", c), {26'd0, out_tag}, 32'(10 + c));
            stepCycle(acc);
            if (acc) idx++;
        end
        #1;
        checkOutput("bpDrainedValid", {31'd0, out_valid}, 32'd0);
        checkOutput("bpQueueEmpty", 32'(expQ.size()), 32'd0);
        @(negedge clk);

        // Flush with two ops in flight: nothing survives, and a later op returns alone.
        applyStimulus(1'b1, 3'd0, 32'h0000_0F00, 32'h0, 6'd20, 5'd1);
        stepCycle(dummy);
        applyStimulus(1'b1, 3'd1, 32'h0000_0F00, 32'h0, 6'd21, 5'd2);
        stepCycle(dummy);
        applyStimulus(1'b1, 3'd2, 32'h0000_0F00, 32'h0, 6'd22, 5'd3);
        flush = 1'b1;
        #1;
        checkOutput("flushInReady", {31'd0, in_ready}, 32'd0);
        stepCycle(dummy);
        flush = 1'b0;
        #1;
        checkOutput("flushOutValid", {31'd0, out_valid}, 32'd0);
        checkOutput("flushInReadyBack", {31'd0, in_ready}, 32'd1);
        stepCycle(acc);
        checkOutput("flushNewAccept", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        stepCycle(dummy);
        #1;
        checkOutput("flushNewValid", {31'd0, out_valid}, 32'd1);
        checkOutput("flushNewTag", {26'd0, out_tag}, 32'd22);
        checkOutput("flushNewResult", out_result, 32'd4);
        stepCycle(dummy);
        #1;
        checkOutput("flushNoStale", {31'd0, out_valid}, 32'd0);
        @(negedge clk);

        // Asynchronous reset while a result is held under stall.
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'd3, 32'h0102_0304, 32'h0, 6'd30, 5'd4);
        stepCycle(dummy);
        in_valid = 1'b0;
        stepCycle(dummy);
        #1;
        checkOutput("preResetValid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncResetValid", {31'd0, out_valid}, 32'd0);
        expQ.delete();
        stallValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("postResetInReady", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            stepCycle(dummy);
            #1;
            checkOutput($sformatf("postResetIdle%0d", c), {31'd0, out_valid}, 32'd0);
        end

        // Randomized traffic with random back-pressure and occasional flushes.
        for (int c = 0; c < 500; c++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0: a = 32'h0;
                1: a = 32'h1 << $urandom_range(0, 31);
                default: a = $urandom;
            endcase
            applyStimulus(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, $urandom,
                          6'($urandom), 5'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            stepCycle(dummy);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) stepCycle(dummy);
        checkOutput("randQueueEmpty", 32'(expQ.size()), 32'd0);
        #1;
        checkOutput("randFinalIdle", {31'd0, out_valid}, 32'd0);
        checkOutput("latencyConst", 32'(BM_LATENCY), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
